// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains the buart holding register into a 2^DEPTH_LOG2 byte FIFO popped by the CPU.
// Define UART_FIFO_DROP_EN to drain and drop bytes (sticky overrun) when full; otherwise backpressure.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_rd,
  input  logic                cpu_rd,
  input  logic                cpu_clr,
  output logic [7:0]          out_data,
  output logic                out_valid,
  output logic [DEPTH_LOG2:0] level,
  output logic                overrun
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, next_state;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic full, take, push, pop;
  assign full = level == (DEPTH_LOG2+1)'(DEPTH);
  assign pop = cpu_rd && level != '0;
`ifdef UART_FIFO_DROP_EN
  assign take = state == IDLE && in_valid;
`else
  assign take = state == IDLE && in_valid && !full;
`endif
  assign push = take && !full;
  assign out_data = mem[rp];
  assign out_valid = level != '0;
  // HOLD gives buart one edge to clear valid so a byte is never captured twice
  always_comb begin
    next_state = (state == HOLD) ? IDLE : (take ? HOLD : IDLE);
  end
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state <= IDLE;
      in_rd <= 1'b0;
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      state <= next_state;
      in_rd <= take;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end
`ifdef UART_FIFO_DROP_EN
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) overrun <= 1'b0;
    else if (take && full) overrun <= 1'b1;
    else if (cpu_clr) overrun <= 1'b0;
  end
`else
  logic unused;
  assign unused = cpu_clr;
  assign overrun = 1'b0;
`endif
endmodule
